data_mem_ctrl: RTL and testbench

Multi-cycle data-memory controller that sits between the core's control signals (`mem_read`, `mem_write`, `funct3`) and a request/grant SRAM-style bus. It services one load or store at a time and stalls the core for the duration. It produces byte enables and lane-shifted write data for stores, and aligned, sign- or zero-extended read data for loads. It is the responder to the memory controls the decoder emits.

---
 rtl/dmem_pkg.sv | 33 +++
 rtl/mem_lane_align.sv | 48 ++++
 rtl/data_mem_ctrl.sv | 151 +++++++++++++++
 tb/tb_data_mem_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller:
// funct3 access sizes, FSM states and an access-legality helper.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RD_WAIT,
    S_DONE
  } dmem_state_t;

  // Misaligned or undefined-size access for the given direction.
  function automatic logic access_bad(
    input logic       we,
    input logic [2:0] f3,
    input logic [1:0] a
  );
    logic ill, mis;
    ill = we ? (f3 > F3_W)
             : (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    mis = ((f3 == F3_H) || (f3 == F3_HU)) ? a[0]
        : (f3 == F3_W) ? (a != 2'b00)
        : 1'b0;
    return ill | mis;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane placement for stores and lane extraction plus
// sign/zero extension for loads; purely combinational.
module mem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] bus_rdata,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        is_b;
  logic        is_h;

  assign byte_sel = bus_rdata[{addr_lo, 3'b000} +: 8];
  assign half_sel = addr_lo[1] ? bus_rdata[31:16]
                               : bus_rdata[15:0];
  assign is_b = (funct3 == F3_B) || (funct3 == F3_BU);
  assign is_h = (funct3 == F3_H) || (funct3 == F3_HU);

  // Anything that is not a byte or halfword moves a full word.
  always_comb begin
    bus_be    = 4'hF;
    bus_wdata = wdata;
    load_data = bus_rdata;
    unique case (1'b1)
      is_b: begin
        bus_be    = 4'b0001 << addr_lo;
        bus_wdata = {4{wdata[7:0]}};
        load_data = {{24{byte_sel[7] & ~funct3[2]}},
                     byte_sel};
      end
      is_h: begin
        bus_be    = 4'b0011 << {addr_lo[1], 1'b0};
        bus_wdata = {2{wdata[15:0]}};
        load_data = {{16{half_sel[15] & ~funct3[2]}},
                     half_sel};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Multi-cycle load/store controller onto a req/gnt SRAM bus.
// DMEM_MISALIGN_TRAP_EN: fault on misaligned/illegal access.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic [31:0]       rdata,
  output logic              rdata_valid,
  output logic              fault,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [31:0]       bus_rdata
);

  dmem_state_t       state;
  dmem_state_t       state_nxt;
  logic [ADDR_W-1:0] cap_addr;
  logic [2:0]        cap_f3;
  logic [31:0]       cap_wdata;
  logic              cap_we;
  logic              fault_pend;
  logic [31:0]       rdata_q;
  logic              req_in;
  logic              bad;
  logic [2:0]        eff_f3;
  logic [3:0]        al_be;
  logic [31:0]       al_wdata;
  logic [31:0]       al_load;

  assign req_in = mem_read | mem_write;

`ifdef DMEM_MISALIGN_TRAP_EN
  assign bad = access_bad(mem_write, funct3, addr[1:0]);
`else
  assign bad = 1'b0;
`endif

  // Store sizes BU/HU/011+ are not real stores: move a word.
  assign eff_f3 = (cap_we && cap_f3 > F3_W) ? F3_W : cap_f3;

  mem_lane_align u_align (
    .funct3    (eff_f3),
    .addr_lo   (cap_addr[1:0]),
    .wdata     (cap_wdata),
    .bus_rdata (bus_rdata),
    .bus_be    (al_be),
    .bus_wdata (al_wdata),
    .load_data (al_load)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:
        if (req_in) state_nxt = bad ? S_DONE : S_REQ;
      S_REQ:
        if (bus_gnt) state_nxt = cap_we ? S_DONE : S_RD_WAIT;
      S_RD_WAIT:
        if (bus_rvalid) state_nxt = S_DONE;
      S_DONE:
        state_nxt = S_IDLE;
      default:
        state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_addr  <= '0;
      cap_f3    <= '0;
      cap_wdata <= '0;
      cap_we    <= 1'b0;
      rdata_q   <= '0;
    end else begin
      if (state == S_IDLE && req_in) begin
        cap_addr  <= addr;
        cap_f3    <= funct3;
        cap_wdata <= wdata;
        cap_we    <= mem_write;
        if (bad) rdata_q <= '0;
      end
      if (state == S_RD_WAIT && bus_rvalid)
        rdata_q <= al_load;
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      fault_pend <= 1'b0;
    else if (state == S_IDLE && req_in)
      fault_pend <= bad;
  end
`else
  assign fault_pend = 1'b0;
`endif

  always_comb begin
    stall       = 1'b0;
    bus_req     = 1'b0;
    bus_we      = 1'b0;
    bus_addr    = '0;
    bus_be      = '0;
    bus_wdata   = '0;
    rdata_valid = 1'b0;
    fault       = 1'b0;
    unique case (state)
      S_IDLE:
        stall = req_in;
      S_REQ: begin
        stall     = 1'b1;
        bus_req   = 1'b1;
        bus_we    = cap_we;
        bus_addr  = {cap_addr[ADDR_W-1:2], 2'b00};
        bus_be    = al_be;
        bus_wdata = al_wdata;
      end
      S_RD_WAIT:
        stall = 1'b1;
      S_DONE: begin
        rdata_valid = ~cap_we & ~fault_pend;
`ifdef DMEM_MISALIGN_TRAP_EN
        fault = fault_pend;
`endif
      end
      default: ;
    endcase
  end

  assign rdata = rdata_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: expected bus beats and
// load results are queued at drive time and popped on output.
module tb_data_mem_ctrl;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        stall, rdata_valid, fault;
  logic [31:0] rdata;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic        bus_gnt, bus_rvalid;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        chk_wd;
  } bus_exp_t;

  bus_exp_t    bus_q[$];
  logic [31:0] rd_q[$];
  int n_chk = 0;
  int n_fail = 0;

  data_mem_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .wdata(wdata),
    .stall(stall), .rdata(rdata),
    .rdata_valid(rdata_valid), .fault(fault),
    .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_gnt(bus_gnt),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Output side of the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_req && bus_gnt) begin
        check("bus_pending", 32'(bus_q.size() != 0), 1);
        if (bus_q.size() != 0) begin
          bus_exp_t e;
          e = bus_q.pop_front();
          check("bus_addr", bus_addr, e.addr);
          check("bus_we", bus_we, e.we);
          check("bus_be", bus_be, e.be);
          if (e.chk_wd) check("bus_wdata", bus_wdata, e.wd);
        end
      end
      if (rdata_valid) begin
        check("rd_pending", 32'(rd_q.size() != 0), 1);
        if (rd_q.size() != 0)
          check("rdata", rdata, rd_q.pop_front());
      end
    end
  end

  task automatic access(
    input string       tag,
    input logic        mr, mw,
    input logic [2:0]  f3,
    input logic [31:0] a, wd, rword,
    input int          gw, rw,
    input logic        exp_bus,
    input logic [3:0]  exp_be,
    input logic [31:0] exp_wd,
    input logic [31:0] exp_rd,
    input logic        exp_valid,
    input logic        exp_fault,
    input int          exp_stall
  );
    int nst, nreq, nval, nflt, rq, rc, cyc;
    logic granted, done, is_load;
    nst = 0; nreq = 0; nval = 0; nflt = 0;
    rq = 0; rc = 0; cyc = 0;
    granted = 1'b0; done = 1'b0;
    is_load = mr & ~mw;
    if (exp_bus)
      bus_q.push_back('{a & 32'hFFFF_FFFC, mw, exp_be,
                        exp_wd, mw});
    if (exp_valid) rd_q.push_back(exp_rd);
    @(posedge clk); #1;
    mem_read = mr; mem_write = mw;
    funct3 = f3; addr = a; wdata = wd;
    bus_rdata = rword;
    while (!done && cyc < 60) begin
      bus_gnt    = bus_req && (rq == gw);
      bus_rvalid = is_load && granted && (rc == rw);
      @(negedge clk);
      cyc++;
      if (stall) nst++;
      else done = 1'b1;
      if (bus_req) nreq++;
      if (rdata_valid) nval++;
      if (fault) nflt++;
      if (bus_req && !bus_gnt) rq++;
      if (granted && !bus_rvalid) rc++;
      if (bus_rvalid) granted = 1'b0;
      if (bus_req && bus_gnt) granted = 1'b1;
      if (done && exp_fault)
        check({tag, "_fault_rdata"}, rdata, 0);
      if (!done) begin
        @(posedge clk); #1;
      end
    end
    bus_gnt = 1'b0; bus_rvalid = 1'b0;
    check({tag, "_done"}, 32'(done), 1);
    check({tag, "_stall"}, nst, exp_stall);
    check({tag, "_valid"}, nval, 32'(exp_valid));
    check({tag, "_fault"}, nflt, 32'(exp_fault));
    if (!exp_bus) check({tag, "_noreq"}, nreq, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    mem_read = 0; mem_write = 0; funct3 = 0;
    addr = 0; wdata = 0;
    bus_gnt = 0; bus_rvalid = 0; bus_rdata = 0;
    @(negedge clk);
    check("rst_req", bus_req, 0);
    check("rst_we", bus_we, 0);
    check("rst_valid", rdata_valid, 0);
    check("rst_fault", fault, 0);
    check("rst_addr", bus_addr, 0);
    check("rst_be", bus_be, 0);
    check("rst_wdata", bus_wdata, 0);
    check("rst_rdata", rdata, 0);
    check("rst_stall", stall, 0);
    @(posedge clk); #1 rst = 1'b0;

    access("sw", 0, 1, F3_W, 32'h104, 32'hDEADBEEF, 0, 0, 0,
           1, 4'hF, 32'hDEADBEEF, 0, 0, 0, 2);
    access("sb", 0, 1, F3_B, 32'h103, 32'h000000A5, 0, 0, 0,
           1, 4'h8, 32'hA5A5A5A5, 0, 0, 0, 2);
    access("sh", 0, 1, F3_H, 32'h102, 32'hCAFE1234, 0, 1, 0,
           1, 4'hC, 32'h12341234, 0, 0, 0, 3);
    access("lb", 1, 0, F3_B, 32'h102, 0, 32'h12803456, 0, 0,
           1, 4'h4, 0, 32'hFFFFFF80, 1, 0, 3);
    access("lbu", 1, 0, F3_BU, 32'h102, 0, 32'h12803456, 0, 0,
           1, 4'h4, 0, 32'h00000080, 1, 0, 3);
    access("lh", 1, 0, F3_H, 32'h200, 0, 32'h00008001, 3, 2,
           1, 4'h3, 0, 32'hFFFF8001, 1, 0, 8);
    access("lhu", 1, 0, F3_HU, 32'h202, 0, 32'h8001ABCD, 0, 1,
           1, 4'hC, 0, 32'h00008001, 1, 0, 4);
    access("lw", 1, 0, F3_W, 32'h10C, 0, 32'h7FFFFFFF, 0, 0,
           1, 4'hF, 0, 32'h7FFFFFFF, 1, 0, 3);
    access("rw_both", 1, 1, F3_W, 32'h110, 32'h55AA55AA, 0, 0, 0,
           1, 4'hF, 32'h55AA55AA, 0, 0, 0, 2);
`ifdef DMEM_MISALIGN_TRAP_EN
    access("lw_mis", 1, 0, F3_W, 32'h101, 0, 32'hA1B2C3D4, 0, 0,
           0, 4'h0, 0, 0, 0, 1, 1);
    access("s_ill", 0, 1, 3'b011, 32'h108, 32'h11223344, 0, 0, 0,
           0, 4'h0, 0, 0, 0, 1, 1);
`else
    access("lw_mis", 1, 0, F3_W, 32'h101, 0, 32'hA1B2C3D4, 0, 0,
           1, 4'hF, 0, 32'hA1B2C3D4, 1, 0, 3);
    access("s_ill", 0, 1, 3'b011, 32'h108, 32'h11223344, 0, 0, 0,
           1, 4'hF, 32'h11223344, 0, 0, 0, 2);
`endif

    // Reset while a load waits for read data.
    bus_q.push_back('{32'h300, 1'b0, 4'hF, 32'h0, 1'b0});
    @(posedge clk); #1;
    mem_read = 1; mem_write = 0; funct3 = F3_W; addr = 32'h300;
    @(posedge clk); #1;
    bus_gnt = bus_req;
    @(posedge clk); #1;
    bus_gnt = 0;
    check("rdwait_stall", stall, 1);
    #2;
    rst = 1'b1; mem_read = 0;
    #1;
    check("rst_async_req", bus_req, 0);
    check("rst_async_stall", stall, 0);
    @(posedge clk); #1;
    rst = 1'b0; bus_rvalid = 1'b1;
    @(posedge clk); #1;
    bus_rvalid = 1'b0;
    access("sw_after_rst", 0, 1, F3_W, 32'h400, 32'h0BADF00D,
           0, 0, 0, 1, 4'hF, 32'h0BADF00D, 0, 0, 0, 2);

    @(posedge clk); #1;
    mem_read = 0; mem_write = 0;
    repeat (2) @(negedge clk);
    check("bus_q_empty", bus_q.size(), 0);
    check("rd_q_empty", rd_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
